// File: rtl/fir_seq_pkg.sv
// ============================================================================
// fir_seq_pkg : op/state encodings and register-map helpers for fir_sequencer
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fir_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_COPY   = 3'd1,
    OP_LOAD_S = 3'd2,
    OP_LOAD_C = 3'd3,
    OP_ADD    = 3'd4,
    OP_SUB    = 3'd5,
    OP_MUL    = 3'd6
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_LWAIT = 4'd2,
    ST_STORE = 4'd3,
    ST_ZERO  = 4'd4,
    ST_SHIFT = 4'd5,
    ST_MUL   = 4'd6,
    ST_ACC   = 4'd7,
    ST_EIDLE = 4'd8
  } state_e;

  localparam int MIN_TAPS = 2;
  localparam int MAX_TAPS = 8;

  // Odd taps add, even taps subtract (bit k-1 set means tap k subtracts).
  localparam logic [MAX_TAPS-1:0] ALT_SIGN_PATTERN = 8'hAA;

  function automatic int sample_reg(input int n);
    return n + 1;
  endfunction

  function automatic int temp_reg(input int n);
    return n + 2;
  endfunction

  function automatic int coef_reg(input int n, input int k);
    return n + 2 + k;
  endfunction

  function automatic int zero_reg(input int n);
    return 2 * n + 3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_tap_counter.sv
// ============================================================================
// fir_tap_counter : clear/load/increment counter with terminal-count flag
// Revision        : 1.0
// ============================================================================
`default_nettype none

module fir_tap_counter
  import fir_seq_pkg::*;
#(
  parameter int WIDTH      = 3,
  parameter int TERMINAL   = 4,
  parameter int LOAD_VALUE = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_next,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  // Next value is exported so the owner can decode registered outputs
  // against the index it is about to occupy.
  always_comb begin
    w_next = r_count;
    if (i_clr) begin
      w_next = '0;
    end else if (i_load) begin
      w_next = WIDTH'(LOAD_VALUE);
    end else if (i_inc) begin
      w_next = r_count + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign o_next = w_next;
  assign o_tc   = (r_count == WIDTH'(TERMINAL));

endmodule

`default_nettype wire

// File: rtl/fir_sequencer.sv
// ============================================================================
// fir_sequencer : N-tap FIR controller for the shared regfile/ALU datapath
// Option macro  : FIR_SEQ_SIGN_MASK_EN adds a per-tap sign_mask input
// Revision      : 1.0
// ============================================================================
`default_nettype none

module fir_sequencer
  import fir_seq_pkg::*;
#(
  parameter  int NUM_TAPS = 4,  // legal range 2..8
  localparam int ADDR_W   = $clog2(2*NUM_TAPS+4)
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                dr,
  input  logic                lc,
  input  logic                overflow,
`ifdef FIR_SEQ_SIGN_MASK_EN
  input  logic [NUM_TAPS-1:0] sign_mask,
`endif
  output logic                cnt_up,
  output logic                clear,
  output logic                modwait,
  output logic [2:0]          op,
  output logic [ADDR_W-1:0]   src1,
  output logic [ADDR_W-1:0]   src2,
  output logic [ADDR_W-1:0]   dest,
  output logic                err,
  output logic                ff_done
);

  localparam int KW = $clog2(NUM_TAPS+1);

  localparam logic [ADDR_W-1:0] c_ACC_REG    = '0;
  localparam logic [ADDR_W-1:0] c_SAMPLE_REG = ADDR_W'(sample_reg(NUM_TAPS));
  localparam logic [ADDR_W-1:0] c_TEMP_REG   = ADDR_W'(temp_reg(NUM_TAPS));
  localparam logic [ADDR_W-1:0] c_COEF_BASE  = ADDR_W'(coef_reg(NUM_TAPS, 0));
  localparam logic [ADDR_W-1:0] c_ZERO_REG   = ADDR_W'(zero_reg(NUM_TAPS));

  state_e                r_state;
  state_e                w_state_next;

  logic                  w_k_clr;
  logic                  w_k_load;
  logic                  w_k_inc;
  logic [KW-1:0]         w_k_next;
  logic                  w_k_tc;
  logic [ADDR_W-1:0]     w_k_addr;

  logic [NUM_TAPS-1:0]   w_sign_src;
  logic [NUM_TAPS-1:0]   r_sign;
  logic                  w_sign_latch;
  logic [(2**KW)-1:0]    w_sign_pad;
  logic                  w_acc_sub;

  op_e                   w_op;
  logic [ADDR_W-1:0]     w_src1;
  logic [ADDR_W-1:0]     w_src2;
  logic [ADDR_W-1:0]     w_dest;
  logic                  w_cnt_up;
  logic                  w_clear;
  logic                  w_modwait;
  logic                  w_err;
  logic                  w_ff_done;

  op_e                   r_op;
  logic [ADDR_W-1:0]     r_src1;
  logic [ADDR_W-1:0]     r_src2;
  logic [ADDR_W-1:0]     r_dest;
  logic                  r_cnt_up;
  logic                  r_clear;
  logic                  r_modwait;
  logic                  r_err;
  logic                  r_ff_done;

`ifdef FIR_SEQ_SIGN_MASK_EN
  assign w_sign_src = sign_mask;
`else
  assign w_sign_src = NUM_TAPS'(ALT_SIGN_PATTERN);
`endif

  // One index serves both the coefficient count and the tap number.
  fir_tap_counter #(
    .WIDTH      (KW),
    .TERMINAL   (NUM_TAPS),
    .LOAD_VALUE (1)
  ) u_tap_counter (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_clr  (w_k_clr),
    .i_load (w_k_load),
    .i_inc  (w_k_inc),
    .o_next (w_k_next),
    .o_tc   (w_k_tc)
  );

  assign w_k_addr   = ADDR_W'(w_k_next);
  assign w_sign_pad = (2**KW)'(r_sign);
  assign w_acc_sub  = w_sign_pad[w_k_next - KW'(1)];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_k_clr      = 1'b0;
    w_k_load     = 1'b0;
    w_k_inc      = 1'b0;
    w_sign_latch = 1'b0;
    w_cnt_up     = 1'b0;
    w_clear      = 1'b0;
    w_ff_done    = 1'b0;

    case (r_state)
      ST_IDLE, ST_EIDLE: begin
        if (lc) begin
          w_state_next = ST_LOAD;
          w_k_load     = 1'b1;
          w_clear      = 1'b1;
        end else if (dr) begin
          w_state_next = ST_STORE;
          w_sign_latch = 1'b1;
        end
      end
      ST_LOAD: begin
        if (w_k_tc) begin
          w_state_next = ST_IDLE;
          w_k_clr      = 1'b1;
        end else begin
          w_state_next = ST_LWAIT;
        end
      end
      ST_LWAIT: begin
        if (lc) begin
          w_state_next = ST_LOAD;
          w_k_inc      = 1'b1;
        end
      end
      ST_STORE: begin
        if (dr) begin
          w_state_next = ST_ZERO;
          w_cnt_up     = 1'b1;
        end else begin
          w_state_next = ST_EIDLE;
        end
      end
      ST_ZERO: begin
        w_state_next = ST_SHIFT;
        w_k_load     = 1'b1;
      end
      ST_SHIFT: begin
        if (w_k_tc) begin
          w_state_next = ST_MUL;
          w_k_load     = 1'b1;
        end else begin
          w_k_inc      = 1'b1;
        end
      end
      ST_MUL: begin
        w_state_next = ST_ACC;
      end
      ST_ACC: begin
        // Overflow wins over completion of the last tap.
        if (overflow) begin
          w_state_next = ST_EIDLE;
          w_k_clr      = 1'b1;
        end else if (w_k_tc) begin
          w_state_next = ST_IDLE;
          w_k_clr      = 1'b1;
          w_ff_done    = 1'b1;
        end else begin
          w_state_next = ST_MUL;
          w_k_inc      = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_k_clr      = 1'b1;
      end
    endcase
  end

  // Registered outputs are decoded from the state and index being entered.
  always_comb begin
    w_op      = OP_NOP;
    w_src1    = '0;
    w_src2    = '0;
    w_dest    = '0;
    w_modwait = 1'b0;
    w_err     = 1'b0;

    case (w_state_next)
      ST_LOAD: begin
        w_op      = OP_LOAD_C;
        w_dest    = c_ZERO_REG - w_k_addr;
        w_modwait = 1'b1;
      end
      ST_STORE: begin
        w_op      = OP_LOAD_S;
        w_dest    = c_SAMPLE_REG;
        w_modwait = 1'b1;
      end
      ST_ZERO: begin
        w_op      = OP_SUB;
        w_src1    = c_ZERO_REG;
        w_src2    = c_ZERO_REG;
        w_dest    = c_ACC_REG;
        w_modwait = 1'b1;
      end
      ST_SHIFT: begin
        w_op      = OP_COPY;
        w_src1    = w_k_addr + ADDR_W'(1);
        w_dest    = w_k_addr;
        w_modwait = 1'b1;
      end
      ST_MUL: begin
        w_op      = OP_MUL;
        w_src1    = w_k_addr;
        w_src2    = c_COEF_BASE + w_k_addr;
        w_dest    = c_TEMP_REG;
        w_modwait = 1'b1;
      end
      ST_ACC: begin
        w_op      = w_acc_sub ? OP_SUB : OP_ADD;
        w_src1    = c_ACC_REG;
        w_src2    = c_TEMP_REG;
        w_dest    = c_ACC_REG;
        w_modwait = 1'b1;
      end
      ST_EIDLE: begin
        w_err     = 1'b1;
      end
      default: begin
        w_op      = OP_NOP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sign <= '0;
    end else if (w_sign_latch) begin
      r_sign <= w_sign_src;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_op      <= OP_NOP;
      r_src1    <= '0;
      r_src2    <= '0;
      r_dest    <= '0;
      r_cnt_up  <= 1'b0;
      r_clear   <= 1'b0;
      r_modwait <= 1'b0;
      r_err     <= 1'b0;
      r_ff_done <= 1'b0;
    end else begin
      r_op      <= w_op;
      r_src1    <= w_src1;
      r_src2    <= w_src2;
      r_dest    <= w_dest;
      r_cnt_up  <= w_cnt_up;
      r_clear   <= w_clear;
      r_modwait <= w_modwait;
      r_err     <= w_err;
      r_ff_done <= w_ff_done;
    end
  end

  assign op      = r_op;
  assign src1    = r_src1;
  assign src2    = r_src2;
  assign dest    = r_dest;
  assign cnt_up  = r_cnt_up;
  assign clear   = r_clear;
  assign modwait = r_modwait;
  assign err     = r_err;
  assign ff_done = r_ff_done;

endmodule

`default_nettype wire

// File: doc/fir_sequencer.md
# fir_sequencer

Parametrised successor to the fixed 4-tap FIR filter controller. It sequences the shared register-file/ALU datapath for an N-tap FIR filter: coefficient loading, sample store, history shift, and a multiply/accumulate pass. Each tap can be added or subtracted, and datapath overflow is reported as an error. It sits between the AHB/slave front end (`dr`, `lc`) and the datapath (`op`, `src1`, `src2`, `dest`).

## Interface
- `NUM_TAPS`, default 4, number of taps, legal range 2..8.
- `ADDR_W` is derived, not a parameter: `ADDR_W` = $clog2(2*NUM_TAPS+4).
- `clk`  in  1  system clock.
- `n_rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `dr`  in  1  data ready: a new sample is present.
- `lc`  in  1  load coefficient: a coefficient is present.
- `overflow`  in  1  datapath overflow for the op currently presented; combinational from the datapath.
- `sign_mask`  in  NUM_TAPS  per-tap subtract select; present only with FIR_SEQ_SIGN_MASK_EN.
- `cnt_up`  out  1  one-cycle pulse per accepted sample.
- `clear`  out  1  one-cycle pulse that clears the sample counter at the start of a coefficient set.
- `modwait`  out  1  datapath busy.
- `op`  out  3  datapath op: NOP=0, COPY=1, LOAD_S=2, LOAD_C=3, ADD=4, SUB=5, MUL=6.
- `src1`  out  ADDR_W  first operand register.
- `src2`  out  ADDR_W  second operand register.
- `dest`  out  ADDR_W  destination register.
- `err`  out  1  error flag.
- `ff_done`  out  1  one-cycle pulse when a filter output is complete.

## Operation
- Register map, with N = NUM_TAPS:
  - R0: accumulator.
  - R1..RN: sample history, R1 oldest.
  - R(N+1): incoming sample.
  - R(N+2): product temp.
  - R(N+3)..R(2N+2): coefficients; coefficient k is in R(N+2+k).
  - R(2N+3): reads as zero.
- States: IDLE, LOAD, LWAIT, STORE, ZERO, SHIFT, MUL, ACC, EIDLE. Tap index k runs 1..N.
- Coefficient loading:
  - `lc` in IDLE or EIDLE → LOAD. Issues LOAD_C to dest R(2N+2), `clear`=1 (first coefficient only), `modwait`=1, `err`=0.
  - LOAD → LWAIT. Issues NOP, `modwait`=0.
  - `lc` in LWAIT → LOAD, next dest decrements by one.
  - After the Nth LOAD (dest R(N+3)) → IDLE.
  - `dr` in LOAD/LWAIT is ignored.
- Sample processing:
  - `dr` in IDLE or EIDLE (with `lc`=0) → STORE. Issues LOAD_S to dest R(N+1), `modwait`=1.
  - In STORE: `dr`=1 → ZERO. Issues SUB R(2N+3)-R(2N+3)→R0, `cnt_up`=1.
  - In STORE: `dr`=0 → EIDLE, `err`=1, `modwait`=0.
  - SHIFT, k=1..N: COPY R(k+1)→Rk, one cycle each.
  - Then for k=1..N:
    - MUL: Rk*R(N+2+k)→R(N+2).
    - ACC: R0 ± R(N+2)→R0.
  - `overflow`=1 sampled during any ACC → EIDLE, `err`=1, all ops NOP, `modwait`=0.
  - After ACC k=N without overflow → IDLE, `ff_done`=1 for one cycle, `modwait`=0.
- Priority: `lc` over `dr` in IDLE/EIDLE.
- `err` holds until leaving EIDLE via `lc` or `dr`.
- Tap sign is latched at STORE. Later changes to `sign_mask` do not affect the sample in flight.

## Timing
- Reset values: state IDLE, k=0, every output 0 (including `op`=NOP, `src1`, `src2`, `dest`).
- All outputs are registered. They are computed on the transition and appear in the cycle the new state is occupied.
- Sample latency: `modwait` is high for exactly 3N+2 cycles (STORE + ZERO + N SHIFT + 2N MUL/ACC). `ff_done` comes in the cycle after the last ACC. N=4 gives 14 cycles.
- `cnt_up`, `clear` and `ff_done` are single-cycle pulses.
- `n_rst` asserted mid-sequence: immediate return to reset values, with no `ff_done` and no `err`.
- `dr` held high after completion starts a new sample from IDLE. There is no edge detection.

## Configuration
- Macro: FIR_SEQ_SIGN_MASK_EN.
- Defined: `sign_mask` port exists. Tap k uses SUB when `sign_mask`[k-1]=1, else ADD.
- Undefined: no port. Fixed alternating pattern: odd k ADD, even k SUB.

## Structure
- `fir_seq_pkg` holds the op enum, the state enum, and the register-index functions (sample, temp, coefficient, zero) in terms of NUM_TAPS.
- One sub-module, `fir_tap_counter`: a load/increment/terminal-count counter for k and the coefficient index.

## Test plan
- Reset then idle: all outputs 0, `modwait`=0 indefinitely with `dr`=`lc`=0.
- Coefficient load, N=4, four `lc` pulses:
  - `dest` sequence 10, 9, 8, 7 with `op`=3.
  - `clear` only with dest 10.
  - Returns to IDLE.
- Sample, N=4, `dr` held 2 cycles, no overflow:
  - Ops STORE(dest 5), SUB 11-11→0, COPY 2→1..5→4.
  - Then MUL 1*7→6, ADD, MUL 2*8, SUB, MUL 3*9, ADD, MUL 4*10, SUB.
  - `ff_done` 14 cycles after STORE.
- `dr` dropped in STORE → `err`=1 next cycle. A following `dr` clears `err` and processes normally.
- `overflow`=1 during the second ACC → EIDLE, `err`=1, no `ff_done`.
- With FIR_SEQ_SIGN_MASK_EN, `sign_mask`=4'b0000 → four ADD ops.
- NUM_TAPS=8 build: coefficient `dest` 18..11, `modwait` for 26 cycles.
